// File: rtl/led_pkg.sv
// led_pkg: shared definitions for the LED slot scheduler.
//   NLED         - width of one colour pattern
//   DEF_PRESCALE - default clk cycles per millisecond tick (12 MHz clock)
//   OWNER_W      - width of a requester index (up to 4 requesters)
//   state_t      - scheduler FSM state
package led_pkg;

    localparam int NLED         = 12;
    localparam int DEF_PRESCALE = 12000;
    localparam int OWNER_W      = 2;

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

endpackage

// File: rtl/led_sched_rr_arb.sv
// rr_arb: combinational round-robin selector.
//   req        - request vector, one bit per requester
//   last_grant - index of the most recent owner
//   valid      - high when any request is pending
//   grant      - winning index, searched from last_grant+1 upwards (wrapping)
module rr_arb
    import led_pkg::*;
#(
    parameter int NREQ = 3
) (
    input  logic [NREQ-1:0]    req,
    input  logic [OWNER_W-1:0] last_grant,
    output logic               valid,
    output logic [OWNER_W-1:0] grant
);

    logic [2*NREQ-1:0] req_dbl;
    logic [NREQ-1:0]   req_rot;

    // Rotating a doubled copy puts the highest-priority requester at bit 0,
    // so a plain priority search over the rotated vector gives round-robin order.
    assign req_dbl = {req, req};
    assign req_rot = NREQ'(req_dbl >> (int'(last_grant) + 1));
    assign valid   = |req;

    always_comb begin
        grant = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                grant = OWNER_W'((int'(last_grant) + 1 + k) % NREQ);
            end
        end
    end

endmodule

// File: rtl/led_sched.sv
// led_sched: grants exclusive, timed ownership of the LED pattern outputs to
// one of NREQ requesters at a time, round-robin.
//   clk, rst             - clock, asynchronous active-high reset
//   req                  - per-requester ownership request (level)
//   pat_yr, pat_bg       - packed per-requester colour patterns (NLED bits each)
//   hold_ms              - packed per-requester slot length in ms (0 acts as 1)
//   idle_yr, idle_bg     - pattern shown while nobody owns the LEDs
//   ack, done            - one-cycle grant / slot-end pulses per requester
//   led_in_yr, led_in_bg - registered pattern to the LED multiplexer
//   owner, busy          - current owner index (valid while busy), HOLD flag
module led_sched
    import led_pkg::*;
#(
    parameter int NREQ     = 3,
    parameter int HOLD_W   = 16,
    parameter int PRESCALE = DEF_PRESCALE
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NLED*NREQ-1:0]   pat_yr,
    input  logic [NLED*NREQ-1:0]   pat_bg,
    input  logic [HOLD_W*NREQ-1:0] hold_ms,
    input  logic [NLED-1:0]        idle_yr,
    input  logic [NLED-1:0]        idle_bg,
    output logic [NREQ-1:0]        ack,
    output logic [NREQ-1:0]        done,
    output logic [NLED-1:0]        led_in_yr,
    output logic [NLED-1:0]        led_in_bg,
    output logic [OWNER_W-1:0]     owner,
    output logic                   busy
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

    state_t               state;
    logic [PW-1:0]        presc;
    logic [HOLD_W-1:0]    ms_cnt;
    logic [OWNER_W-1:0]   last_grant;

    logic                 arb_valid;
    logic [OWNER_W-1:0]   arb_grant;
    logic [HOLD_W-1:0]    grant_hold;
    logic                 presc_wrap;
    logic                 expire;
    logic                 owner_release;

    rr_arb #(
        .NREQ(NREQ)
    ) u_arb (
        .req       (req),
        .last_grant(last_grant),
        .valid     (arb_valid),
        .grant     (arb_grant)
    );

    assign grant_hold    = hold_ms[arb_grant*HOLD_W +: HOLD_W];
    assign presc_wrap    = (presc == PRESC_MAX);
    // The slot expires on the wrap that would take the ms counter to zero.
    assign expire        = presc_wrap && (ms_cnt <= HOLD_W'(1));
    assign owner_release = ~|(req & (NREQ'(1) << owner));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ack        <= '0;
            done       <= '0;
            busy       <= 1'b0;
            owner      <= '0;
            led_in_yr  <= '0;
            led_in_bg  <= '0;
            presc      <= '0;
            ms_cnt     <= '0;
            last_grant <= OWNER_W'(NREQ - 1);
        end else begin
            ack  <= '0;
            done <= '0;
            case (state)
                IDLE: begin
                    if (arb_valid) begin
                        state     <= HOLD;
                        ack       <= NREQ'(1) << arb_grant;
                        owner     <= arb_grant;
                        busy      <= 1'b1;
                        // Pattern is captured once here and held for the slot.
                        led_in_yr <= pat_yr[arb_grant*NLED +: NLED];
                        led_in_bg <= pat_bg[arb_grant*NLED +: NLED];
                        presc     <= '0;
                        ms_cnt    <= (grant_hold == '0) ? HOLD_W'(1) : grant_hold;
                    end else begin
                        led_in_yr <= idle_yr;
                        led_in_bg <= idle_bg;
                    end
                end
                HOLD: begin
                    // Release and expiry share one exit, so done pulses once.
                    if (owner_release || expire) begin
                        state      <= IDLE;
                        done       <= NREQ'(1) << owner;
                        busy       <= 1'b0;
                        last_grant <= owner;
                        led_in_yr  <= idle_yr;
                        led_in_bg  <= idle_bg;
                        presc      <= '0;
                        ms_cnt     <= '0;
                    end else if (presc_wrap) begin
                        presc  <= '0;
                        ms_cnt <= ms_cnt - 1'b1;
                    end else begin
                        presc <= presc + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/led_sched.md
LED_SCHED -- requirements
Module: led_sched

Interface
REQ-001 Parameter NREQ, default 3, number of requesters (2..4).
REQ-002 Parameter HOLD_W, default 16, width of per-request hold time in milliseconds.
REQ-003 Parameter PRESCALE, default 12000, clk cycles per millisecond tick (12 MHz).
REQ-004 clk  input  1  single clock, rising edge; all state on this clock.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req  input  NREQ  per-requester ownership request, level; held high for the whole slot.
REQ-007 pat_yr  input  12*NREQ  colour-A pattern of requester i at bits [12i+11:12i].
REQ-008 pat_bg  input  12*NREQ  colour-B pattern of requester i, same packing.
REQ-009 hold_ms  input  HOLD_W*NREQ  slot length of requester i in ms.
REQ-010 idle_yr, idle_bg  input  12 each  pattern shown while no owner.
REQ-011 ack  output  NREQ  one-cycle pulse, bit i, on grant to requester i.
REQ-012 done  output  NREQ  one-cycle pulse, bit i, when requester i's slot ends.
REQ-013 led_in_yr, led_in_bg  output  12 each  registered pattern to the LED multiplexer.
REQ-014 owner  output  2  index of current owner; valid only when busy=1.
REQ-015 busy  output  1  high in HOLD state.

Function
REQ-016 FSM states: IDLE, HOLD; no other states.
REQ-017 IDLE: led_in_yr/led_in_bg SHALL equal idle_yr/idle_bg, registered (one-cycle latency).
REQ-018 IDLE with any req bit set: grant by round-robin starting at (last_grant+1) mod NREQ; move to HOLD next edge.
REQ-019 Grant edge: ack[i] pulses, owner=i, busy=1, pattern of requester i latched and driven from the same edge; latency req-to-ack = 1 cycle.
REQ-020 Pattern is latched once at grant; requester pattern changes during HOLD SHALL NOT affect outputs.
REQ-021 Slot timer: prescaler counts 0..PRESCALE-1; ms counter loaded with hold_ms[i] at grant, decremented on each prescaler wrap; expiry when counter reaches 0 at a wrap.
REQ-022 hold_ms=0 SHALL be treated as 1 ms.
REQ-023 Prescaler SHALL reset to 0 at grant, so slot length = max(hold_ms,1)*PRESCALE cycles exactly.
REQ-024 Owner deasserting req during HOLD SHALL end the slot on the next edge (early release).
REQ-025 Slot end (expiry or release): done[owner] pulses, busy=0, state IDLE, last_grant=owner, idle pattern driven from that edge.
REQ-026 Minimum one IDLE cycle between consecutive slots; no back-to-back grant.
REQ-027 Expiry and release in the same cycle: single done pulse.
REQ-028 Non-owner req changes during HOLD SHALL be ignored until IDLE.
REQ-029 ack and done SHALL never both be high for the same requester in one cycle.

Reset
REQ-030 On rst: state IDLE, ack=0, done=0, busy=0, owner=0, led_in_yr=0, led_in_bg=0, counters 0, last_grant=NREQ-1 (requester 0 has first priority).
REQ-031 Reset mid-slot SHALL abort the slot with no done pulse.
REQ-032 First edge after reset release drives the idle pattern.

Structure
REQ-033 Shared package led_pkg holds NLED=12, state type, and default PRESCALE.
REQ-034 Round-robin selection SHALL be a sub-module rr_arb (req, last_grant in; valid, grant index out; combinational).

Verification
REQ-035 req=3'b001, hold_ms[0]=2, PRESCALE=4: ack[0] one cycle after req; pattern held exactly 8 cycles; done[0] then idle pattern.
REQ-036 req=3'b111 held, all hold_ms=1: grant order 0,1,2,0, each separated by one IDLE cycle.
REQ-037 Owner 1 drops req mid-slot: done[1] next edge, idle pattern, no further ack while req=0.
REQ-038 hold_ms=0: slot lasts PRESCALE cycles, identical to hold_ms=1.
REQ-039 rst asserted mid-HOLD: outputs zero asynchronously, no done pulse; after release req0 granted first.
REQ-040 pat_yr of owner changed during HOLD: led_in_yr unchanged until slot end.
